// File: rtl/hydra_pkg.sv
// Shared types and sizing for the ingress write path.
// Arbiter, picker and output-queue scheduler all size themselves from these.
package hydra_pkg;

   // Number of ingress ports sharing the packet-memory write channel.
   localparam int NPORT   = 16;
   // Priority field width; numerically lower value means more urgent.
   localparam int PRIOR_W = 3;
   // Length field width; a packet is length+1 words including the control frame.
   localparam int LEN_W   = 9;
   // Width of a port index.
   localparam int PORT_W  = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef logic [PORT_W-1:0]  port_idx_t;
   typedef logic [PRIOR_W-1:0] prior_t;
   typedef logic [LEN_W-1:0]   len_t;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Round-robin pointer after reset: the highest port, so port 0 wins the
   // first tie.
   localparam port_idx_t LAST_GRANT_INIT = port_idx_t'(NPORT - 1);

endpackage

// File: rtl/prio_rr_picker.sv
// Combinational strict-priority picker with round-robin tie-break.
// Lowest priority value wins; among equal winners the first index strictly
// after last_grant (wrapping) is chosen.
module prio_rr_picker
   import hydra_pkg::*;
(
   input  logic [NPORT-1:0]         req,
   input  logic [NPORT*PRIOR_W-1:0] req_prior,
   input  logic [PORT_W-1:0]        last_grant,
   output logic                     win_vld,
   output logic [PORT_W-1:0]        win_idx
);

   prior_t           prior_arr [NPORT];
   prior_t           min_prior;
   logic [NPORT-1:0] elig;
   int               rr_pos;
   port_idx_t        rr_cand;

   // Unpack the per-port priority fields.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
         assign prior_arr[gi] = req_prior[gi*PRIOR_W +: PRIOR_W];
      end
   endgenerate

   // Most urgent (numerically smallest) priority among active requesters.
   always_comb begin
      min_prior = '1;
      for (int i = 0; i < NPORT; i++) begin
         if (req[i] && (prior_arr[i] < min_prior)) begin
            min_prior = prior_arr[i];
         end
      end
   end

   // A port is eligible if it requests at the winning priority level.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_elig
         assign elig[gi] = req[gi] && (prior_arr[gi] == min_prior);
      end
   endgenerate

   // Rotating search starting just after last_grant; scanning from the far
   // end backwards lets the nearest eligible port overwrite the result.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      rr_pos  = 0;
      rr_cand = '0;
      for (int k = NPORT; k >= 1; k--) begin
         rr_pos  = (int'(last_grant) + k) % NPORT;
         rr_cand = port_idx_t'(rr_pos);
         if (elig[rr_cand]) begin
            win_vld = 1'b1;
            win_idx = rr_cand;
         end
      end
   end

endmodule

// File: rtl/ingress_write_arbiter.sv
// Arbiter for the single packet-memory write channel shared by all ingress
// ports. Grants one port, holds the channel until its packet is complete or
// it stalls too long, then re-arbitrates.
module ingress_write_arbiter
   import hydra_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORT-1:0]         req,
   input  logic [NPORT*PRIOR_W-1:0] req_prior,
   input  logic [NPORT*LEN_W-1:0]   req_length,
   input  logic [NPORT-1:0]         data_vld_in,
   input  logic                     mem_full,
   output logic [NPORT-1:0]         grant,
   output logic [PORT_W-1:0]        sel_port,
   output logic                     busy,
   output logic                     xfer_done,
   output logic                     xfer_abort
);

   localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_SAT   = '1;

   arb_state_t          state_reg,      state_next;
   logic [NPORT-1:0]    grant_reg,      grant_next;
   port_idx_t           sel_port_reg,   sel_port_next;
   port_idx_t           last_grant_reg, last_grant_next;
   len_t                len_lat_reg,    len_lat_next;
   len_t                word_cnt_reg,   word_cnt_next;
   logic [IDLE_W-1:0]   idle_cnt_reg,   idle_cnt_next;
   logic                xfer_done_reg,  xfer_done_next;
   logic                xfer_abort_reg, xfer_abort_next;

   len_t                len_arr [NPORT];
   logic                win_vld;
   port_idx_t           win_idx;
   logic                owner_vld;

   // Unpack the per-port length fields.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_len
         assign len_arr[gi] = req_length[gi*LEN_W +: LEN_W];
      end
   endgenerate

   prio_rr_picker u_picker (
      .req        (req),
      .req_prior  (req_prior),
      .last_grant (last_grant_reg),
      .win_vld    (win_vld),
      .win_idx    (win_idx)
   );

   // Only the current owner's word-valid is ever counted.
   assign owner_vld = data_vld_in[sel_port_reg];

   // State and datapath registers; reset returns everything to idle with no
   // completion or abort pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         sel_port_reg   <= '0;
         last_grant_reg <= LAST_GRANT_INIT;
         len_lat_reg    <= '0;
         word_cnt_reg   <= '0;
         idle_cnt_reg   <= '0;
         xfer_done_reg  <= 1'b0;
         xfer_abort_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         sel_port_reg   <= sel_port_next;
         last_grant_reg <= last_grant_next;
         len_lat_reg    <= len_lat_next;
         word_cnt_reg   <= word_cnt_next;
         idle_cnt_reg   <= idle_cnt_next;
         xfer_done_reg  <= xfer_done_next;
         xfer_abort_reg <= xfer_abort_next;
      end
   end

   // Next-state: arbitrate in IDLE, count owner words and idle cycles in XFER.
   always_comb begin
      state_next      = state_reg;
      grant_next      = '0;
      sel_port_next   = sel_port_reg;
      last_grant_next = last_grant_reg;
      len_lat_next    = len_lat_reg;
      word_cnt_next   = word_cnt_reg;
      idle_cnt_next   = idle_cnt_reg;
      xfer_done_next  = 1'b0;
      xfer_abort_next = 1'b0;

      case (state_reg)
         IDLE: begin
            // A full memory blocks new packets only; it never interrupts one.
            if (win_vld && !mem_full) begin
               state_next           = XFER;
               grant_next           = '0;
               grant_next[win_idx]  = 1'b1;
               sel_port_next        = win_idx;
               last_grant_next      = win_idx;
               len_lat_next         = len_arr[win_idx];
               word_cnt_next        = '0;
               idle_cnt_next        = '0;
            end
         end

         XFER: begin
            if (owner_vld) begin
               idle_cnt_next = '0;
               if (word_cnt_reg == len_lat_reg) begin
                  // Final word of length+1 accepted.
                  state_next     = IDLE;
                  xfer_done_next = 1'b1;
                  word_cnt_next  = '0;
               end else begin
                  word_cnt_next = word_cnt_reg + 1'b1;
               end
            end else if (idle_cnt_reg == IDLE_LIMIT) begin
               // Owner stalled too long; release the channel. last_grant
               // still points at it, so it loses the next tie.
               state_next      = IDLE;
               xfer_abort_next = 1'b1;
               idle_cnt_next   = '0;
               word_cnt_next   = '0;
            end else if (idle_cnt_reg != IDLE_SAT) begin
               idle_cnt_next = idle_cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign grant      = grant_reg;
   assign sel_port   = sel_port_reg;
   assign busy       = (state_reg == XFER);
   assign xfer_done  = xfer_done_reg;
   assign xfer_abort = xfer_abort_reg;

endmodule
